// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-requester (CPU, loader) arbiter in front of a single SRAM controller
//
// Purpose:
//   Grants one of two requesters (CPU or loader) access to a shared SRAM
//   controller. Contention is resolved by fixed CPU priority or round-robin.
//   Each transaction occupies one GRANT state until mem_ready, followed by
//   one IDLE cycle so the controller always sees a fresh request edge.
//
// Parameters:
//   FIXED_CPU_PRIO  1 = CPU always wins contention, 0 = round-robin
//   CNT_W           width of the per-requester completed-transaction counters
//
// Ports:
//   clk, rst                        clock, asynchronous active-low reset
//   cpu_read_en, cpu_write_en       CPU request (level, held until cpu_ready)
//   cpu_address, cpu_write_data     CPU request address / store data
//   cpu_read_data, cpu_ready        CPU load result / ready (0 = freeze)
//   ldr_*                           loader port, same meaning as the CPU port
//   mem_read_en, mem_write_en       request to the SRAM controller
//   mem_address, mem_write_data     address / store data to the controller
//   mem_read_data, mem_ready        controller response (ready = completion)
//   cpu_count, ldr_count            saturating completed-transaction counters

module sram_arbiter #(
  parameter int FIXED_CPU_PRIO = 0,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             cpu_read_en,
  input  logic             cpu_write_en,
  input  logic [31:0]      cpu_address,
  input  logic [31:0]      cpu_write_data,
  output logic [31:0]      cpu_read_data,
  output logic             cpu_ready,

  input  logic             ldr_read_en,
  input  logic             ldr_write_en,
  input  logic [31:0]      ldr_address,
  input  logic [31:0]      ldr_write_data,
  output logic [31:0]      ldr_read_data,
  output logic             ldr_ready,

  output logic             mem_read_en,
  output logic             mem_write_en,
  output logic [31:0]      mem_address,
  output logic [31:0]      mem_write_data,
  input  logic [31:0]      mem_read_data,
  input  logic             mem_ready,

  output logic [CNT_W-1:0] cpu_count,
  output logic [CNT_W-1:0] ldr_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT_CPU = 2'd1,
    GRANT_LDR = 2'd2
  } state_t;

  localparam logic          GR_CPU  = 1'b0;
  localparam logic          GR_LDR  = 1'b1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state;
  state_t state_next;

  logic        last_grant;
  logic        cpu_pending;
  logic        ldr_pending;
  logic        win_cpu;

  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic [31:0]      cpu_rd_q;
  logic [31:0]      ldr_rd_q;
  logic [CNT_W-1:0] cpu_cnt_q;
  logic [CNT_W-1:0] ldr_cnt_q;

  logic granted;
  logic cpu_done;
  logic ldr_done;

  assign cpu_pending = cpu_read_en | cpu_write_en;
  assign ldr_pending = ldr_read_en | ldr_write_en;

  assign granted  = (state != IDLE);
  assign cpu_done = (state == GRANT_CPU) && mem_ready;
  assign ldr_done = (state == GRANT_LDR) && mem_ready;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Under contention the CPU wins when fixed priority is
  // enabled, otherwise whoever was not served last.
  always_comb begin
    state_next = state;
    win_cpu    = 1'b0;
    unique case (state)
      IDLE: begin
        if (cpu_pending && ldr_pending) begin
          win_cpu    = (FIXED_CPU_PRIO != 0) || (last_grant == GR_LDR);
          state_next = win_cpu ? GRANT_CPU : GRANT_LDR;
        end else if (cpu_pending) begin
          win_cpu    = 1'b1;
          state_next = GRANT_CPU;
        end else if (ldr_pending) begin
          state_next = GRANT_LDR;
        end
      end
      GRANT_CPU, GRANT_LDR: begin
        if (mem_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latches: captured only on the IDLE->GRANT edge so the mem_*
  // outputs never depend combinationally on requester inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_write <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
    end else if (state == IDLE && state_next == GRANT_CPU) begin
      lat_write <= cpu_write_en;
      lat_addr  <= cpu_address;
      lat_wdata <= cpu_write_data;
    end else if (state == IDLE && state_next == GRANT_LDR) begin
      lat_write <= ldr_write_en;
      lat_addr  <= ldr_address;
      lat_wdata <= ldr_write_data;
    end
  end

  // Completion bookkeeping: fairness pointer, counters, read data capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= GR_LDR;
      cpu_cnt_q  <= '0;
      ldr_cnt_q  <= '0;
      cpu_rd_q   <= 32'd0;
      ldr_rd_q   <= 32'd0;
    end else begin
      if (cpu_done) begin
        last_grant <= GR_CPU;
        if (cpu_cnt_q != '1) begin
          cpu_cnt_q <= cpu_cnt_q + CNT_ONE;
        end
        if (!lat_write) begin
          cpu_rd_q <= mem_read_data;
        end
      end
      if (ldr_done) begin
        last_grant <= GR_LDR;
        if (ldr_cnt_q != '1) begin
          ldr_cnt_q <= ldr_cnt_q + CNT_ONE;
        end
        if (!lat_write) begin
          ldr_rd_q <= mem_read_data;
        end
      end
    end
  end

  // Memory side: driven purely from state and latches; IDLE forces zeros
  assign mem_read_en    = granted && !lat_write;
  assign mem_write_en   = granted &&  lat_write;
  assign mem_address    = granted ? lat_addr  : 32'd0;
  assign mem_write_data = granted ? lat_wdata : 32'd0;

  // Ready: high when the requester is idle and not being served, or in its
  // own completion cycle. A granted requester that dropped its enables still
  // sees 0 until the transaction completes.
  always_comb begin
    cpu_ready = 1'b0;
    ldr_ready = 1'b0;
    if (state == GRANT_CPU) begin
      cpu_ready = mem_ready;
    end else begin
      cpu_ready = !cpu_pending;
    end
    if (state == GRANT_LDR) begin
      ldr_ready = mem_ready;
    end else begin
      ldr_ready = !ldr_pending;
    end
  end

  // Read data bypasses the register in the completion cycle so the requester
  // can consume it in the same cycle ready rises.
  assign cpu_read_data = cpu_done ? mem_read_data : cpu_rd_q;
  assign ldr_read_data = ldr_done ? mem_read_data : ldr_rd_q;

  assign cpu_count = cpu_cnt_q;
  assign ldr_count = ldr_cnt_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter
//
// Purpose:
//   Drives directed request/response sequences into a round-robin instance
//   (dut) and a fixed-CPU-priority instance with 2-bit counters (dut_fx),
//   which share all inputs, and checks outputs against hand-computed values.

module tb_sram_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_read_en, cpu_write_en;
  logic [31:0] cpu_address, cpu_write_data;
  logic        ldr_read_en, ldr_write_en;
  logic [31:0] ldr_address, ldr_write_data;
  logic [31:0] mem_read_data;
  logic        mem_ready;

  logic [31:0] cpu_read_data, ldr_read_data;
  logic        cpu_ready, ldr_ready;
  logic        mem_read_en, mem_write_en;
  logic [31:0] mem_address, mem_write_data;
  logic [15:0] cpu_count, ldr_count;

  logic [31:0] fx_cpu_read_data, fx_ldr_read_data;
  logic        fx_cpu_ready, fx_ldr_ready;
  logic        fx_mem_read_en, fx_mem_write_en;
  logic [31:0] fx_mem_address, fx_mem_write_data;
  logic [1:0]  fx_cpu_count, fx_ldr_count;

  int checks;
  int errors;

  sram_arbiter #(.FIXED_CPU_PRIO(0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .cpu_read_en(cpu_read_en), .cpu_write_en(cpu_write_en),
    .cpu_address(cpu_address), .cpu_write_data(cpu_write_data),
    .cpu_read_data(cpu_read_data), .cpu_ready(cpu_ready),
    .ldr_read_en(ldr_read_en), .ldr_write_en(ldr_write_en),
    .ldr_address(ldr_address), .ldr_write_data(ldr_write_data),
    .ldr_read_data(ldr_read_data), .ldr_ready(ldr_ready),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .mem_ready(mem_ready),
    .cpu_count(cpu_count), .ldr_count(ldr_count)
  );

  sram_arbiter #(.FIXED_CPU_PRIO(1), .CNT_W(2)) dut_fx (
    .clk(clk), .rst(rst),
    .cpu_read_en(cpu_read_en), .cpu_write_en(cpu_write_en),
    .cpu_address(cpu_address), .cpu_write_data(cpu_write_data),
    .cpu_read_data(fx_cpu_read_data), .cpu_ready(fx_cpu_ready),
    .ldr_read_en(ldr_read_en), .ldr_write_en(ldr_write_en),
    .ldr_address(ldr_address), .ldr_write_data(ldr_write_data),
    .ldr_read_data(fx_ldr_read_data), .ldr_ready(fx_ldr_ready),
    .mem_read_en(fx_mem_read_en), .mem_write_en(fx_mem_write_en),
    .mem_address(fx_mem_address), .mem_write_data(fx_mem_write_data),
    .mem_read_data(mem_read_data), .mem_ready(mem_ready),
    .cpu_count(fx_cpu_count), .ldr_count(fx_ldr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cpu_read_en = 0; cpu_write_en = 0; cpu_address = 0; cpu_write_data = 0;
    ldr_read_en = 0; ldr_write_en = 0; ldr_address = 0; ldr_write_data = 0;
    mem_read_data = 0; mem_ready = 0;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    tick();
    tick();
    checks++; if (mem_read_en !== 1'b0 || mem_write_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b%b expected 00", mem_read_en, mem_write_en); end
    checks++; if (mem_address !== 32'd0 || mem_write_data !== 32'd0) begin errors++; $display("FAIL reset_mem_bus: got %h/%h expected 0/0", mem_address, mem_write_data); end
    checks++; if (cpu_ready !== 1'b1 || ldr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b%b expected 11", cpu_ready, ldr_ready); end
    checks++; if (cpu_count !== 16'd0 || ldr_count !== 16'd0 || cpu_read_data !== 32'd0) begin errors++; $display("FAIL reset_regs: got %h %h %h expected 0 0 0", cpu_count, ldr_count, cpu_read_data); end
    #2;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_cpu_read();
    cpu_read_en = 1; cpu_address = 32'h100;
    #1;
    checks++; if (cpu_ready !== 1'b0 || mem_read_en !== 1'b0) begin errors++; $display("FAIL rd_idle_pending: got rdy=%b ren=%b expected 0 0", cpu_ready, mem_read_en); end
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++; if (mem_read_en !== 1'b1 || mem_address !== 32'h100 || cpu_ready !== 1'b0) begin errors++; $display("FAIL rd_wait_c%0d: got ren=%b addr=%h rdy=%b expected 1 100 0", c, mem_read_en, mem_address, cpu_ready); end
    end
    tick();
    mem_ready = 1; mem_read_data = 32'hDEADBEEF;
    #1;
    checks++; if (cpu_ready !== 1'b1 || cpu_read_data !== 32'hDEADBEEF || mem_read_en !== 1'b1) begin errors++; $display("FAIL rd_complete: got rdy=%b data=%h ren=%b expected 1 deadbeef 1", cpu_ready, cpu_read_data, mem_read_en); end
    cpu_read_en = 0;
    tick();
    mem_ready = 0; mem_read_data = 32'h0;
    #1;
    checks++; if (cpu_read_data !== 32'hDEADBEEF || cpu_count !== 16'd1 || mem_read_en !== 1'b0 || cpu_ready !== 1'b1) begin errors++; $display("FAIL rd_after: got data=%h cnt=%0d ren=%b rdy=%b expected deadbeef 1 0 1", cpu_read_data, cpu_count, mem_read_en, cpu_ready); end
  endtask

  task automatic test_write_wins();
    cpu_read_en = 1; cpu_write_en = 1; cpu_address = 32'h200; cpu_write_data = 32'h5A5A5A5A;
    tick();
    checks++; if (mem_write_en !== 1'b1 || mem_read_en !== 1'b0 || mem_write_data !== 32'h5A5A5A5A) begin errors++; $display("FAIL wr_wins: got wen=%b ren=%b wdata=%h expected 1 0 5a5a5a5a", mem_write_en, mem_read_en, mem_write_data); end
    mem_ready = 1; mem_read_data = 32'h11111111;
    #1;
    checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL wr_complete_ready: got %b expected 1", cpu_ready); end
    cpu_read_en = 0; cpu_write_en = 0;
    tick();
    mem_ready = 0; mem_read_data = 32'h0;
    #1;
    checks++; if (cpu_count !== 16'd2 || mem_write_en !== 1'b0 || cpu_read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_after: got cnt=%0d wen=%b data=%h expected 2 0 deadbeef", cpu_count, mem_write_en, cpu_read_data); end
  endtask

  task automatic test_addr_hold();
    ldr_read_en = 1; ldr_address = 32'h20;
    tick();
    ldr_address = 32'h40;
    #1;
    checks++; if (mem_address !== 32'h20 || mem_read_en !== 1'b1 || ldr_ready !== 1'b0) begin errors++; $display("FAIL hold_c1: got addr=%h ren=%b rdy=%b expected 20 1 0", mem_address, mem_read_en, ldr_ready); end
    tick();
    checks++; if (mem_address !== 32'h20) begin errors++; $display("FAIL hold_c2: got addr=%h expected 20", mem_address); end
    mem_ready = 1; mem_read_data = 32'h12345678;
    #1;
    checks++; if (ldr_ready !== 1'b1 || ldr_read_data !== 32'h12345678 || mem_address !== 32'h20) begin errors++; $display("FAIL hold_complete: got rdy=%b data=%h addr=%h expected 1 12345678 20", ldr_ready, ldr_read_data, mem_address); end
    ldr_read_en = 0;
    tick();
    mem_ready = 0; mem_read_data = 32'h0;
    #1;
    checks++; if (ldr_count !== 16'd1 || ldr_read_data !== 32'h12345678 || cpu_read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL hold_after: got cnt=%0d ldata=%h cdata=%h expected 1 12345678 deadbeef", ldr_count, ldr_read_data, cpu_read_data); end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_addr;
    logic        exp_cpu;
    pulse_reset();
    cpu_write_en = 1; cpu_address = 32'h1000; cpu_write_data = 32'hC0;
    ldr_write_en = 1; ldr_address = 32'h2000; ldr_write_data = 32'h1D;
    mem_ready = 1;
    #1;
    checks++; if (cpu_ready !== 1'b0 || ldr_ready !== 1'b0) begin errors++; $display("FAIL rr_idle_ready: got %b%b expected 00", cpu_ready, ldr_ready); end
    for (int t = 0; t < 4; t++) begin
      exp_cpu  = (t % 2 == 0);
      exp_addr = exp_cpu ? 32'h1000 : 32'h2000;
      tick();
      checks++; if (mem_write_en !== 1'b1 || mem_address !== exp_addr || cpu_ready !== exp_cpu || ldr_ready !== !exp_cpu) begin errors++; $display("FAIL rr_grant_%0d: got wen=%b addr=%h rdy=%b%b expected 1 %h %b%b", t, mem_write_en, mem_address, cpu_ready, ldr_ready, exp_addr, exp_cpu, !exp_cpu); end
      tick();
      checks++; if (mem_write_en !== 1'b0) begin errors++; $display("FAIL rr_idle_%0d: got wen=%b expected 0", t, mem_write_en); end
    end
    checks++; if (cpu_count !== 16'd2 || ldr_count !== 16'd2) begin errors++; $display("FAIL rr_counts: got %0d/%0d expected 2/2", cpu_count, ldr_count); end
    clear_inputs();
    tick();
  endtask

  task automatic test_fixed_prio();
    pulse_reset();
    cpu_read_en = 1; cpu_address = 32'h300;
    ldr_read_en = 1; ldr_address = 32'h400;
    mem_ready = 1; mem_read_data = 32'hCAFE0000;
    for (int c = 1; c <= 8; c++) begin
      tick();
      checks++; if (fx_ldr_ready !== 1'b0) begin errors++; $display("FAIL fx_ldr_ready_c%0d: got %b expected 0", c, fx_ldr_ready); end
    end
    checks++; if (fx_ldr_count !== 2'd0) begin errors++; $display("FAIL fx_ldr_count: got %0d expected 0", fx_ldr_count); end
    checks++; if (fx_cpu_count !== 2'd3) begin errors++; $display("FAIL fx_cpu_count_sat: got %0d expected 3", fx_cpu_count); end
    checks++; if (ldr_count !== 16'd2 || cpu_count !== 16'd2) begin errors++; $display("FAIL rr_shared_counts: got %0d/%0d expected 2/2", cpu_count, ldr_count); end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    ldr_write_en = 1; ldr_address = 32'h30; ldr_write_data = 32'h77;
    tick();
    checks++; if (mem_write_en !== 1'b1 || mem_address !== 32'h30) begin errors++; $display("FAIL rm_granted: got wen=%b addr=%h expected 1 30", mem_write_en, mem_address); end
    rst = 1'b0;
    #1;
    checks++; if (mem_write_en !== 1'b0 || mem_read_en !== 1'b0 || mem_address !== 32'd0) begin errors++; $display("FAIL rm_async_drop: got wen=%b ren=%b addr=%h expected 0 0 0", mem_write_en, mem_read_en, mem_address); end
    checks++; if (ldr_count !== 16'd0) begin errors++; $display("FAIL rm_count: got %0d expected 0", ldr_count); end
    rst = 1'b1;
    #1;
    checks++; if (ldr_ready !== 1'b0) begin errors++; $display("FAIL rm_idle_ready: got %b expected 0", ldr_ready); end
    tick();
    checks++; if (mem_write_en !== 1'b1 || mem_address !== 32'h30 || mem_write_data !== 32'h77) begin errors++; $display("FAIL rm_regrant: got wen=%b addr=%h wd=%h expected 1 30 77", mem_write_en, mem_address, mem_write_data); end
    mem_ready = 1;
    #1;
    ldr_write_en = 0;
    tick();
    mem_ready = 0;
    #1;
    checks++; if (ldr_count !== 16'd1 || mem_write_en !== 1'b0) begin errors++; $display("FAIL rm_after: got cnt=%0d wen=%b expected 1 0", ldr_count, mem_write_en); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    clear_inputs();
    test_reset();
    test_cpu_read();
    test_write_wins();
    test_addr_hold();
    test_round_robin();
    test_fixed_prio();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter FIXED_CPU_PRIO, default 0: 1 = CPU always wins contention; 0 = round-robin.
REQ-002 Parameter CNT_W, default 16: width of the completed-transaction counters.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 cpu_read_en, cpu_write_en  input  1 each  CPU request, level, held until cpu_ready=1.
REQ-006 cpu_address, cpu_write_data  input  32 each  CPU request address and store data.
REQ-007 cpu_read_data  output  32  CPU load result.
REQ-008 cpu_ready  output  1  0 = CPU must freeze; 1 = idle or completing.
REQ-009 ldr_read_en, ldr_write_en, ldr_address, ldr_write_data, ldr_read_data, ldr_ready  --  loader port, same directions, widths and meaning as the CPU port.
REQ-010 mem_read_en, mem_write_en  output  1 each  request to SRAM_Controller.
REQ-011 mem_address, mem_write_data  output  32 each  to SRAM_Controller.
REQ-012 mem_read_data  input  32  from SRAM_Controller.
REQ-013 mem_ready  input  1  from SRAM_Controller; 1 in the completion cycle of an active request.
REQ-014 cpu_count, ldr_count  output  CNT_W each  completed transactions per requester.

Function
REQ-015 FSM states: IDLE, GRANT_CPU, GRANT_LDR; state is registered.
REQ-016 IDLE: mem_read_en=mem_write_en=0; a requester is pending if its read_en or write_en is 1.
REQ-017 IDLE with exactly one requester pending: next state is that requester's GRANT.
REQ-018 IDLE with both pending: FIXED_CPU_PRIO=1 grants CPU; otherwise grants the requester not recorded in last_grant.
REQ-019 On the IDLE->GRANT edge, latch op, address and write_data from the winner into registers; the latched op is write if write_en=1 (write wins when both enables are 1), else read.
REQ-020 GRANT_x: drive mem_read_en/mem_write_en/mem_address/mem_write_data from the latches only; later changes on requester inputs are ignored.
REQ-021 GRANT_x with mem_ready=1 is the completion cycle:
  - next state IDLE;
  - last_grant <= x;
  - x_count increments, saturating at all-ones;
  - for a read, latch mem_read_data into x's read_data register.
REQ-022 Minimum occupancy is 2 cycles per transaction (GRANT + IDLE); IDLE always holds mem enables at 0 for one cycle so the controller sees a fresh request.
REQ-023 x_ready is combinational:
  - 1 when x is not pending and not granted;
  - 1 in x's completion cycle;
  - 0 otherwise, including the IDLE cycle in which x is pending.
REQ-024 x_read_data: in x's completion cycle, mem_read_data passes through combinationally; all other cycles, the registered value.
REQ-025 The non-granted requester sees ready=0 for the whole transaction if pending; the granted transaction is never preempted.
REQ-026 A requester dropping its enables while granted does not abort the transaction; the transaction completes and is counted.
REQ-027 No combinational path from requester inputs to mem_* outputs.

Reset
REQ-028 rst=0 asynchronously forces:
  - state=IDLE; last_grant=LDR, so CPU wins the first contention;
  - latches, read_data registers and counters = 0;
  - mem_read_en=mem_write_en=0, mem_address=mem_write_data=0.
REQ-029 Reset mid-transaction abandons the transaction without counting it; ready outputs follow REQ-023 from the next cycle.

Verification
REQ-030 CPU read only, address 0x100, mem_ready low 3 cycles then high with data 0xDEADBEEF:
  - mem_read_en high cycles 1-4;
  - cpu_ready=0 until cycle 4;
  - cpu_read_data=0xDEADBEEF from cycle 4 onward;
  - cpu_count=1.
REQ-031 Both requesters post writes in the same cycle, FIXED_CPU_PRIO=0, after reset: grant order CPU, LDR, CPU, LDR over four back-to-back transactions; counts 2/2.
REQ-032 FIXED_CPU_PRIO=1, CPU requests continuously, loader waiting: loader never granted; ldr_ready stays 0; ldr_count=0.
REQ-033 CPU asserts read_en and write_en together with data 0x5A5A5A5A: mem_write_en=1, mem_read_en=0, mem_write_data=0x5A5A5A5A.
REQ-034 Loader changes address from 0x20 to 0x40 after grant: mem_address stays 0x20 until completion.
REQ-035 Assert rst low during GRANT_LDR: mem enables drop asynchronously; ldr_count unchanged; next request is granted from IDLE.
